prio_strobe_decoder: RTL and testbench

Receive side of the priority-encoder path: takes a 3-bit priority code (the encoder's output format) and expands it into a registered one-hot strobe.
The strobe is held for a programmable number of cycles, followed by an optional guard gap.
Codes are accepted through a valid/ready handshake and gated by an enable, mirroring the encoder's enable.
The block sits between the encoder/arbiter result and the per-channel service logic, which needs a clean timed select line.

---
 rtl/prio_strobe_pkg.sv | 12 +
 rtl/prio_strobe_decoder_if.sv | 11 +
 rtl/prio_strobe_cnt.sv | 18 +
 rtl/prio_strobe_decoder.sv | 77 +++++++
 tb/tb_prio_strobe_decoder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/prio_strobe_pkg.sv
// prio_strobe_pkg: state type, default parameters and one-hot helper shared by the strobe decoder.
package prio_strobe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CODE_W = 3;
  localparam int DEF_PULSE_LEN = 4;
  localparam int DEF_GAP_LEN = 1;
  localparam int MAX_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;
  function automatic logic [MAX_WIDTH-1:0] onehot_of(input int unsigned code);
    return code < MAX_WIDTH ? MAX_WIDTH'(1) << code : '0;
  endfunction
endpackage

// File: rtl/prio_strobe_decoder_if.sv
// prio_strobe_decoder_if: code handshake and strobe outputs of the strobe decoder.
interface prio_strobe_decoder_if import prio_strobe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CODE_W = DEF_CODE_W
) ();
  logic en, in_valid, in_ready, out_active, out_done, out_err;
  logic [CODE_W-1:0] in_code;
  logic [WIDTH-1:0] out_onehot;
  modport master (output en, in_valid, in_code, input in_ready, out_onehot, out_active, out_done, out_err);
  modport slave (input en, in_valid, in_code, output in_ready, out_onehot, out_active, out_done, out_err);
endinterface

// File: rtl/prio_strobe_cnt.sv
// prio_strobe_cnt: loadable down-counter that holds at zero, shared by the strobe and guard phases.
module prio_strobe_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (load) cnt_q <= value;
    else if (en && !zero) cnt_q <= cnt_q - W'(1);
  assign zero = cnt_q == '0;
endmodule

// File: rtl/prio_strobe_decoder.sv
// prio_strobe_decoder: expands an accepted priority code into a timed one-hot strobe plus guard gap.
// Define PRIO_STROBE_DEC_TRISTATE_EN to float out_onehot while en is low.
module prio_strobe_decoder import prio_strobe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CODE_W = DEF_CODE_W,
  parameter int PULSE_LEN = DEF_PULSE_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN
) (
  input logic clk,
  input logic rst,
  prio_strobe_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN) + 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
  localparam logic [CODE_W:0] CODE_LIM = (CODE_W + 1)'(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] onehot_q, mask;
  logic [CNT_W-1:0] load_val;
  logic active_q, err_q, accept, legal, load, cnt_zero;
  assign accept = bus.in_valid && bus.in_ready;
  assign legal = {1'b0, bus.in_code} < CODE_LIM;
  assign mask = WIDTH'(onehot_of(32'(bus.in_code)));
  assign bus.in_ready = bus.en && state_q == IDLE;
  assign bus.out_active = active_q && bus.en;
  assign bus.out_err = err_q;
  // an abort landing on the last strobe cycle must not report completion
  assign bus.out_done = bus.en && state_q == DRIVE && cnt_zero;
`ifdef PRIO_STROBE_DEC_TRISTATE_EN
  assign bus.out_onehot = bus.en ? onehot_q : 'z;
`else
  assign bus.out_onehot = bus.en ? onehot_q : '0;
`endif
  prio_strobe_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .en(state_q != IDLE),
    .load(load),
    .value(load_val),
    .zero(cnt_zero)
  );
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    load_val = '0;
    if (!bus.en) begin
      state_d = IDLE;
      load = 1'b1;
    end else
      case (state_q)
        IDLE: if (accept && legal) begin
          state_d = DRIVE;
          load = 1'b1;
          load_val = PULSE_LOAD;
        end
        DRIVE: if (cnt_zero) begin
          state_d = GAP_LEN > 0 ? GAP : IDLE;
          load = 1'b1;
          load_val = GAP_LOAD;
        end
        GAP: if (cnt_zero) state_d = IDLE;
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      onehot_q <= '0;
      active_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      onehot_q <= state_d != DRIVE ? '0 : state_q == IDLE ? mask : onehot_q;
      active_q <= state_d == DRIVE;
      err_q <= accept && !legal;
    end
endmodule

// File: tb/tb_prio_strobe_decoder.sv
// tb_prio_strobe_decoder: directed checks of strobe timing, abort, illegal codes and busy behaviour.
module tb_prio_strobe_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  prio_strobe_decoder_if #(.WIDTH(8), .CODE_W(3)) a_if ();
  prio_strobe_decoder_if #(.WIDTH(8), .CODE_W(3)) b_if ();
  prio_strobe_decoder_if #(.WIDTH(6), .CODE_W(3)) c_if ();
  prio_strobe_decoder #(.WIDTH(8), .CODE_W(3), .PULSE_LEN(4), .GAP_LEN(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  prio_strobe_decoder #(.WIDTH(8), .CODE_W(3), .PULSE_LEN(1), .GAP_LEN(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  prio_strobe_decoder #(.WIDTH(6), .CODE_W(3), .PULSE_LEN(4), .GAP_LEN(1)) dut_c (.clk(clk), .rst(rst), .bus(c_if.slave));
  task automatic wait_ready_a();
    int n = 0;
    while (!a_if.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++; if (a_if.in_ready !== 1'b1) $display("FAIL idle_wait in_ready got %b want 1", a_if.in_ready); else passed++;
  endtask
  task automatic accept_a(input logic [2:0] code);
    @(negedge clk);
    a_if.in_valid = 1'b1;
    a_if.in_code = code;
    @(posedge clk);
    #1 a_if.in_valid = 1'b0;
  endtask
  task automatic test_reset();
    a_if.en = 1'b1; a_if.in_valid = 1'b0; a_if.in_code = '0;
    b_if.en = 1'b1; b_if.in_valid = 1'b0; b_if.in_code = '0;
    c_if.en = 1'b1; c_if.in_valid = 1'b0; c_if.in_code = '0;
    #2;
    total++; if (a_if.out_onehot !== 8'h00) $display("FAIL rst_onehot got %h want 00", a_if.out_onehot); else passed++;
    total++; if (a_if.out_active !== 1'b0) $display("FAIL rst_active got %b want 0", a_if.out_active); else passed++;
    total++; if (a_if.out_done !== 1'b0) $display("FAIL rst_done got %b want 0", a_if.out_done); else passed++;
    total++; if (a_if.out_err !== 1'b0) $display("FAIL rst_err got %b want 0", a_if.out_err); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (a_if.in_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", a_if.in_ready); else passed++;
  endtask
  task automatic test_strobe();
    logic [7:0] exp_oh;
    @(negedge clk);
    total++; if (a_if.in_ready !== 1'b1) $display("FAIL strobe_ready0 got %b want 1", a_if.in_ready); else passed++;
    a_if.in_valid = 1'b1;
    a_if.in_code = 3'd5;
    @(posedge clk);
    #1 a_if.in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_oh = k <= 4 ? 8'h20 : 8'h00;
      total++; if (a_if.out_onehot !== exp_oh) $display("FAIL strobe_onehot c%0d got %h want %h", k, a_if.out_onehot, exp_oh); else passed++;
      total++; if (a_if.out_active !== (k <= 4)) $display("FAIL strobe_active c%0d got %b want %b", k, a_if.out_active, k <= 4); else passed++;
      total++; if (a_if.out_done !== (k == 4)) $display("FAIL strobe_done c%0d got %b want %b", k, a_if.out_done, k == 4); else passed++;
      total++; if (a_if.in_ready !== (k >= 6)) $display("FAIL strobe_ready c%0d got %b want %b", k, a_if.in_ready, k >= 6); else passed++;
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] exp_oh [1:4] = '{8'h80, 8'h00, 8'h01, 8'h00};
    logic [1:4] exp_done = 4'b1010;
    logic [1:4] exp_rdy = 4'b0101;
    @(negedge clk);
    b_if.in_valid = 1'b1;
    b_if.in_code = 3'd7;
    @(posedge clk);
    #1 b_if.in_code = 3'd0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++; if (b_if.out_onehot !== exp_oh[k]) $display("FAIL b2b_onehot c%0d got %h want %h", k, b_if.out_onehot, exp_oh[k]); else passed++;
      total++; if (b_if.out_done !== exp_done[k]) $display("FAIL b2b_done c%0d got %b want %b", k, b_if.out_done, exp_done[k]); else passed++;
      total++; if (b_if.in_ready !== exp_rdy[k]) $display("FAIL b2b_ready c%0d got %b want %b", k, b_if.in_ready, exp_rdy[k]); else passed++;
      if (k == 3) b_if.in_valid = 1'b0;
    end
  endtask
  task automatic test_abort();
    logic [7:0] exp_off;
`ifdef PRIO_STROBE_DEC_TRISTATE_EN
    exp_off = 8'bzzzz_zzzz;
`else
    exp_off = 8'h00;
`endif
    wait_ready_a();
    accept_a(3'd2);
    @(negedge clk);
    total++; if (a_if.out_onehot !== 8'h04) $display("FAIL abort_c1 got %h want 04", a_if.out_onehot); else passed++;
    @(negedge clk);
    total++; if (a_if.out_onehot !== 8'h04) $display("FAIL abort_c2 got %h want 04", a_if.out_onehot); else passed++;
    a_if.en = 1'b0;
    @(posedge clk);
    #1;
    total++; if (a_if.out_onehot !== exp_off) $display("FAIL abort_onehot got %h want %h", a_if.out_onehot, exp_off); else passed++;
    total++; if (a_if.out_active !== 1'b0) $display("FAIL abort_active got %b want 0", a_if.out_active); else passed++;
    total++; if (a_if.out_done !== 1'b0) $display("FAIL abort_done got %b want 0", a_if.out_done); else passed++;
    total++; if (a_if.in_ready !== 1'b0) $display("FAIL abort_ready got %b want 0", a_if.in_ready); else passed++;
    a_if.in_valid = 1'b1;
    a_if.in_code = 3'd3;
    @(posedge clk);
    #1 a_if.en = 1'b1;
    a_if.in_valid = 1'b0;
    @(negedge clk);
    total++; if (a_if.out_onehot !== 8'h00) $display("FAIL abort_noaccept got %h want 00", a_if.out_onehot); else passed++;
    total++; if (a_if.in_ready !== 1'b1) $display("FAIL abort_idle got %b want 1", a_if.in_ready); else passed++;
    accept_a(3'd1);
    repeat (4) @(negedge clk);
    total++; if (a_if.out_done !== 1'b1) $display("FAIL last_done got %b want 1", a_if.out_done); else passed++;
    a_if.en = 1'b0;
    #1;
    total++; if (a_if.out_done !== 1'b0) $display("FAIL last_abort_done got %b want 0", a_if.out_done); else passed++;
    @(posedge clk);
    #1;
    total++; if (a_if.out_onehot !== exp_off) $display("FAIL last_abort_onehot got %h want %h", a_if.out_onehot, exp_off); else passed++;
    a_if.en = 1'b1;
    @(negedge clk);
    total++; if (a_if.in_ready !== 1'b1) $display("FAIL last_abort_ready got %b want 1", a_if.in_ready); else passed++;
  endtask
  task automatic test_illegal();
    logic [2:0] codes [3] = '{3'd6, 3'd7, 3'd5};
    logic [5:0] exp_oh [3] = '{6'h00, 6'h00, 6'h20};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (c_if.in_ready !== 1'b1) $display("FAIL ill_ready_pre%0d got %b want 1", i, c_if.in_ready); else passed++;
      c_if.in_valid = 1'b1;
      c_if.in_code = codes[i];
      @(posedge clk);
      #1 c_if.in_valid = 1'b0;
      total++; if (c_if.out_err !== (i < 2)) $display("FAIL ill_err%0d got %b want %b", i, c_if.out_err, i < 2); else passed++;
      total++; if (c_if.out_onehot !== exp_oh[i]) $display("FAIL ill_onehot%0d got %h want %h", i, c_if.out_onehot, exp_oh[i]); else passed++;
      total++; if (c_if.in_ready !== (i < 2)) $display("FAIL ill_ready%0d got %b want %b", i, c_if.in_ready, i < 2); else passed++;
      @(posedge clk);
      #1;
      total++; if (c_if.out_err !== 1'b0) $display("FAIL ill_err_clr%0d got %b want 0", i, c_if.out_err); else passed++;
    end
  endtask
  task automatic test_busy();
    logic [7:0] exp_oh;
    wait_ready_a();
    accept_a(3'd3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_oh = k <= 4 ? 8'h08 : k == 7 ? 8'h02 : 8'h00;
      total++; if (a_if.out_onehot !== exp_oh) $display("FAIL busy_onehot c%0d got %h want %h", k, a_if.out_onehot, exp_oh); else passed++;
      total++; if (a_if.in_ready !== (k == 6)) $display("FAIL busy_ready c%0d got %b want %b", k, a_if.in_ready, k == 6); else passed++;
      if (k == 1) begin
        a_if.in_valid = 1'b1;
        a_if.in_code = 3'd1;
      end
      if (k == 7) a_if.in_valid = 1'b0;
    end
  endtask
  task automatic test_reset_mid_drive();
    wait_ready_a();
    accept_a(3'd5);
    repeat (2) @(negedge clk);
    total++; if (a_if.out_onehot !== 8'h20) $display("FAIL rmid_pre got %h want 20", a_if.out_onehot); else passed++;
    rst = 1'b1;
    #1;
    total++; if (a_if.out_onehot !== 8'h00) $display("FAIL rmid_onehot got %h want 00", a_if.out_onehot); else passed++;
    total++; if (a_if.out_active !== 1'b0) $display("FAIL rmid_active got %b want 0", a_if.out_active); else passed++;
    total++; if (a_if.in_ready !== 1'b1) $display("FAIL rmid_ready_in got %b want 1", a_if.in_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (a_if.in_ready !== 1'b1) $display("FAIL rmid_ready got %b want 1", a_if.in_ready); else passed++;
    total++; if (a_if.out_onehot !== 8'h00) $display("FAIL rmid_post got %h want 00", a_if.out_onehot); else passed++;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_strobe();
    test_back_to_back();
    test_abort();
    test_illegal();
    test_busy();
    test_reset_mid_drive();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
